place_ships_ctl: RTL

//  Control-side writer for one board_mem instance (clk = control_clk domain). Clears the board
//  on reset/clear, then turns left mouse clicks over the board into ship-cell writes on the

---
 rtl/warships_pkg.sv | 22 ++
 rtl/place_ships_ctl_if.sv | 21 ++
 rtl/sync_edge_det.sv | 25 ++
 rtl/place_ships_ctl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/warships_pkg.sv
// Shared warships types: board cell encoding, board geometry and placement FSM states.
package warships_pkg;

   localparam int unsigned BOARD_X_SIZE = 12;
   localparam int unsigned BOARD_Y_SIZE = 12;
   localparam int unsigned BOARD_ADDR_W = 8;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'd0,
      CELL_SHIP  = 2'd1,
      CELL_MISS  = 2'd2,
      CELL_HIT   = 2'd3
   } cell_t;

   typedef enum logic [1:0] {
      StClear,
      StIdle,
      StCalc,
      StWrite
   } place_state_t;

endpackage

// File: rtl/place_ships_ctl_if.sv
// Board memory write port: the controller drives it, board_mem receives it.
interface place_ships_ctl_if;
   import warships_pkg::*;

   logic [BOARD_ADDR_W-1:0] board_write_addr;
   cell_t                   board_write_data;
   logic                    board_write_enable;

   modport master (
      output board_write_addr,
      output board_write_data,
      output board_write_enable
   );

   modport slave (
      input board_write_addr,
      input board_write_data,
      input board_write_enable
   );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a rising-edge detector giving a registered 1-cycle pulse.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   // [0],[1] synchronise; [2] holds the previous synchronised value.
   logic [2:0] sync_q;
   logic       pulse_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], din};
         pulse_q <= sync_q[1] & ~sync_q[2];
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/place_ships_ctl.sv
// Ship placement controller: clears the board, then turns mouse clicks into board_mem writes.
// Define SHIP_TOGGLE_EN to let a click on an occupied cell remove the ship again.
module place_ships_ctl
   import warships_pkg::*;
#(
   parameter int unsigned X_POS          = 100,
   parameter int unsigned Y_POS          = 200,
   parameter int unsigned CELL_SIZE_LOG2 = 5,
   parameter int unsigned X_SIZE         = BOARD_X_SIZE,
   parameter int unsigned Y_SIZE         = BOARD_Y_SIZE,
   parameter int unsigned SHIP_CELLS     = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                place_en,
   input  logic [11:0]         mouse_x_pos,
   input  logic [11:0]         mouse_y_pos,
   input  logic                mouse_left,
   place_ships_ctl_if.master   board,
   output logic [4:0]          ships_placed,
   output logic                placement_done,
   output logic                busy
);

   place_state_t state_q, state_d;

   logic                     click;
   logic [3:0]               row_q, col_q;
   logic signed [12:0]       dx_q, dy_q;
   logic [X_SIZE*Y_SIZE-1:0] shadow_q;
   logic [4:0]               count_q;

   logic                    we_q, we_d;
   logic [BOARD_ADDR_W-1:0] addr_q, addr_d;
   cell_t                   data_q, data_d;
   logic                    busy_q, busy_d;

   logic        sweep_last;
   logic [12:0] dx_cell, dy_cell;
   logic [3:0]  calc_col, calc_row;
   logic [7:0]  cell_idx;
   logic        in_range, occupied, do_place, do_remove;

   sync_edge_det u_left_edge (
      .clk   (clk),
      .rst   (rst),
      .din   (mouse_left),
      .pulse (click)
   );

   assign sweep_last = (row_q == 4'(Y_SIZE - 1)) && (col_q == 4'(X_SIZE - 1));

   // Negative offsets are rejected by the sign bits, so an unsigned shift is safe here.
   assign dx_cell  = 13'(dx_q) >> CELL_SIZE_LOG2;
   assign dy_cell  = 13'(dy_q) >> CELL_SIZE_LOG2;
   assign in_range = !dx_q[12] && !dy_q[12] &&
                     (dx_cell < 13'(X_SIZE)) && (dy_cell < 13'(Y_SIZE));
   assign calc_col = dx_cell[3:0];
   assign calc_row = dy_cell[3:0];
   assign cell_idx = 8'(calc_row) * 8'(X_SIZE) + 8'(calc_col);
   assign occupied = in_range && shadow_q[cell_idx];
   assign do_place = in_range && !occupied && (count_q < 5'(SHIP_CELLS));
`ifdef SHIP_TOGGLE_EN
   assign do_remove = occupied;
`else
   assign do_remove = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= StClear;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StClear: if (sweep_last) state_d = StIdle;
         StIdle:  if (click && place_en) state_d = StCalc;
         StCalc:  state_d = in_range ? StWrite : StIdle;
         StWrite: state_d = StIdle;
         default: state_d = StClear;
      endcase
      if (clear) state_d = StClear;
   end

   // Next values of the registered write-port outputs; WE lands in the WRITE cycle.
   always_comb begin
      we_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      busy_d = 1'b0;
      if (clear) begin
         busy_d = 1'b1;
      end else begin
         unique case (state_q)
            StClear: begin
               we_d   = 1'b1;
               addr_d = {row_q, col_q};
               data_d = CELL_EMPTY;
               busy_d = 1'b1;
            end
            StCalc: begin
               if (do_place || do_remove) begin
                  we_d   = 1'b1;
                  addr_d = {calc_row, calc_col};
                  data_d = do_place ? CELL_SHIP : CELL_EMPTY;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= CELL_EMPTY;
         busy_q <= 1'b0;
      end else begin
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
         busy_q <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         row_q    <= '0;
         col_q    <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         shadow_q <= '0;
         count_q  <= '0;
      end else begin
         unique case (state_q)
            StClear: begin
               if (col_q == 4'(X_SIZE - 1)) begin
                  col_q <= '0;
                  row_q <= sweep_last ? 4'd0 : row_q + 4'd1;
               end else begin
                  col_q <= col_q + 4'd1;
               end
            end
            StIdle: begin
               if (click && place_en) begin
                  dx_q <= {1'b0, mouse_x_pos} - 13'(X_POS);
                  dy_q <= {1'b0, mouse_y_pos} - 13'(Y_POS);
               end
            end
            StCalc: begin
               if (do_place) begin
                  shadow_q[cell_idx] <= 1'b1;
                  count_q            <= count_q + 5'd1;
               end else if (do_remove) begin
                  shadow_q[cell_idx] <= 1'b0;
                  count_q            <= count_q - 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign board.board_write_enable = we_q;
   assign board.board_write_addr   = addr_q;
   assign board.board_write_data   = data_q;
   assign ships_placed             = count_q;
   assign placement_done           = (count_q == 5'(SHIP_CELLS));
   assign busy                     = busy_q;

endmodule
